// File: rtl/color_pkg.sv
// color_pkg: shared colour encodings and decoder state type
package color_pkg;
  typedef enum logic {COLOR_BLUE = 1'b0, COLOR_RED = 1'b1} color_state_e;
  typedef enum logic [1:0] {UNSYNC, BLUE, RED, ERROR} dec_state_e;
  localparam logic [1:0] COLOR_CODE_BLUE = 2'h1;
  localparam logic [1:0] COLOR_CODE_RED = 2'h2;
  function automatic logic code_legal(input logic [1:0] c);
    return c == COLOR_CODE_BLUE || c == COLOR_CODE_RED;
  endfunction
endpackage

// File: rtl/color_evt_buf.sv
// color_evt_buf: one-entry valid/ready event register with sticky overflow flag
module color_evt_buf #(
  parameter int RUN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             push_color,
  input  logic [RUN_W-1:0] push_run,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic             evt_color,
  output logic [RUN_W-1:0] evt_run,
  output logic             evt_ovf
);
  logic pop;
  assign pop = evt_valid & evt_ready;
  // a push always loads; it only counts as lost data if the old entry was never taken
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_color <= 1'b0;
      evt_run   <= '0;
      evt_ovf   <= 1'b0;
    end else if (push) begin
      evt_valid <= 1'b1;
      evt_color <= push_color;
      evt_run   <= push_run;
      evt_ovf   <= evt_ovf | (evt_valid & ~evt_ready);
    end else if (pop) begin
      evt_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/color_code_decoder.sv
// color_code_decoder: tracks encoder colour state from its wire code, counts changes and run lengths
module color_code_decoder
  import color_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int RUN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             code_valid,
  input  logic [1:0]       code,
  input  logic             clear,
  output logic             locked,
  output logic             color,
  output logic             err,
  output logic [CNT_W-1:0] change_cnt,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             evt_color,
  output logic [RUN_W-1:0] evt_run,
  output logic             evt_ovf
);
  dec_state_e       state, state_n;
  logic [RUN_W-1:0] run, run_n;
  logic [CNT_W-1:0] cnt_n;
  logic             push, same;
  assign locked = state == BLUE || state == RED;
  assign color  = state == RED;
  assign err    = state == ERROR;
  assign same   = (state == BLUE && code == COLOR_CODE_BLUE) || (state == RED && code == COLOR_CODE_RED);
  // state, run counter and change counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= UNSYNC;
      run        <= '0;
      change_cnt <= '0;
    end else begin
      state      <= state_n;
      run        <= run_n;
      change_cnt <= cnt_n;
    end
  end
  // next state; clear wins over a sampled code, and ERROR ignores codes until cleared
  always_comb begin
    state_n = state;
    run_n   = run;
    cnt_n   = change_cnt;
    push    = 1'b0;
    if (clear) begin
      state_n = UNSYNC;
    end else if (code_valid) begin
      case (state)
        UNSYNC: begin
          state_n = !code_legal(code) ? ERROR : code == COLOR_CODE_BLUE ? BLUE : RED;
          run_n   = code_legal(code) ? RUN_W'(1) : run;
          cnt_n   = code_legal(code) ? '0 : change_cnt;
        end
        BLUE, RED: begin
          if (!code_legal(code)) begin
            state_n = ERROR;
          end else if (same) begin
            run_n = &run ? run : run + RUN_W'(1);
          end else begin
            state_n = state == BLUE ? RED : BLUE;
            run_n   = RUN_W'(1);
            cnt_n   = &change_cnt ? change_cnt : change_cnt + CNT_W'(1);
            push    = 1'b1;
          end
        end
        default: state_n = ERROR;
      endcase
    end
  end
  color_evt_buf #(.RUN_W(RUN_W)) u_evt_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_color (code == COLOR_CODE_RED),
    .push_run   (run),
    .evt_ready  (evt_ready),
    .evt_valid  (evt_valid),
    .evt_color  (evt_color),
    .evt_run    (evt_run),
    .evt_ovf    (evt_ovf)
  );
endmodule

// File: tb/tb_color_code_decoder.sv
// tb_color_code_decoder: table-driven directed checks of the colour code decoder
module tb_color_code_decoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0, code_valid = 1'b0, clear = 1'b0, evt_ready = 1'b0;
  logic [1:0] code = 2'h0;
  logic       locked, color, err, evt_valid, evt_color, evt_ovf;
  logic [7:0] change_cnt;
  logic [3:0] evt_run;
  int         passed = 0, total = 0;

  always #5 clk = ~clk;

  color_code_decoder #(.CNT_W(8), .RUN_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_valid (code_valid),
    .code       (code),
    .clear      (clear),
    .locked     (locked),
    .color      (color),
    .err        (err),
    .change_cnt (change_cnt),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_color  (evt_color),
    .evt_run    (evt_run),
    .evt_ovf    (evt_ovf)
  );

  // exp = {locked, color, err, change_cnt[7:0], evt_valid, evt_color, evt_run[3:0], evt_ovf}
  typedef struct packed {
    logic        rst_n;
    logic        cv;
    logic [1:0]  code;
    logic        clr;
    logic        rdy;
    logic [17:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic cv, input logic [1:0] c, input logic cl,
                              input logic rd, input logic lk, input logic co, input logic er,
                              input logic [7:0] cn, input logic ev, input logic ec,
                              input logic [3:0] ru, input logic eo);
    vec_t v;
    v.rst_n = r;
    v.cv    = cv;
    v.code  = c;
    v.clr   = cl;
    v.rdy   = rd;
    v.exp   = {lk, co, er, cn, ev, ec, ru, eo};
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rst_n      = v.rst_n;
    code_valid = v.cv;
    code       = v.code;
    clear      = v.clr;
    evt_ready  = v.rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [17:0] exp);
    logic [17:0] act;
    act = {locked, color, err, change_cnt, evt_valid, evt_color, evt_run, evt_ovf};
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got lk/co/er/cnt/ev/ec/run/ovf=%b/%b/%b/%0d/%b/%b/%0d/%b want %b/%b/%b/%0d/%b/%b/%0d/%b",
                  name, act[17], act[16], act[15], act[14:7], act[6], act[5], act[4:1], act[0],
                  exp[17], exp[16], exp[15], exp[14:7], exp[6], exp[5], exp[4:1], exp[0]);
  endtask

  vec_t tbl[$];

  initial begin
    //         rst cv code clr rdy  lk co er cnt ev ec run ovf
    tbl.push_back(mk(0, 0, 2'h0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 2'h1, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 2'h1, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 2'h1, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 2'h1, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 2'h2, 0, 1,  1, 1, 0, 1, 1, 1, 3, 0));
    tbl.push_back(mk(1, 1, 2'h2, 0, 1,  1, 1, 0, 1, 0, 1, 3, 0));
    tbl.push_back(mk(1, 1, 2'h3, 0, 1,  0, 0, 1, 1, 0, 1, 3, 0));
    tbl.push_back(mk(1, 1, 2'h1, 0, 1,  0, 0, 1, 1, 0, 1, 3, 0));
    tbl.push_back(mk(1, 1, 2'h1, 1, 1,  0, 0, 0, 1, 0, 1, 3, 0));
    tbl.push_back(mk(1, 1, 2'h1, 0, 1,  1, 0, 0, 0, 0, 1, 3, 0));
    tbl.push_back(mk(1, 1, 2'h2, 0, 0,  1, 1, 0, 1, 1, 1, 1, 0));
    tbl.push_back(mk(1, 1, 2'h1, 0, 0,  1, 0, 0, 2, 1, 0, 1, 1));
    tbl.push_back(mk(1, 0, 2'h2, 0, 1,  1, 0, 0, 2, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 2'h2, 0, 0,  1, 0, 0, 2, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 2'h0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 2'h1, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 2'h2, 0, 0,  1, 1, 0, 1, 1, 1, 1, 0));
    tbl.push_back(mk(1, 1, 2'h1, 0, 1,  1, 0, 0, 2, 1, 0, 1, 0));
    tbl.push_back(mk(1, 1, 2'h1, 0, 1,  1, 0, 0, 2, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 2'h0, 0, 1,  0, 0, 1, 2, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 2'h2, 1, 1,  0, 0, 0, 2, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 2'h0, 0, 1,  0, 0, 1, 2, 0, 0, 1, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end
    // run-length saturation at 2^RUN_W-1 with RUN_W=4
    apply(mk(0, 0, 2'h0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0));
    check("sat_reset", 18'h0);
    for (int i = 0; i < 20; i++) apply(mk(1, 1, 2'h2, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0));
    check("sat_locked_red", {1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 4'd0, 1'b0});
    apply(mk(1, 1, 2'h1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    check("sat_evt_run15", {1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 4'd15, 1'b0});
    apply(mk(1, 1, 2'h1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    check("evt_stable_stall", {1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 4'd15, 1'b0});
    apply(mk(0, 1, 2'h2, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    check("midrun_reset", 18'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/color_code_decoder.md
# color_code_decoder

Receive-side counterpart of the Color state-machine encoder: samples the 2-bit Moore output code (Blue = 2'h1, Red = 2'h2), tracks which state the transmitter is in, and validates the code stream. It counts colour changes and measures run lengths. Each colour change is delivered as an event through a one-entry valid/ready buffer. It sits downstream of the encoder and feeds status/monitor logic.

## Interface
- CNT_W, default 8: width of the saturating colour-change counter.
- RUN_W, default 8: width of the saturating run-length counter and event run field.

- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- code_valid  in  1  `code` is sampled this cycle.
- code  in  2  colour code: 2'h1 = Blue, 2'h2 = Red; 2'h0 and 2'h3 are illegal.
- clear  in  1  leaves ERROR and restarts synchronisation.
- locked  out  1  decoder is in BLUE or RED.
- color  out  1  current colour, Color_state encoding (Blue = 0, Red = 1); valid only when `locked`.
- err  out  1  decoder is in ERROR.
- change_cnt  out  CNT_W  number of colour changes since lock; saturates at all-ones.
- evt_valid  out  1  event buffer holds an event.
- evt_ready  in  1  consumer accepts the event.
- evt_color  out  1  colour entered by the change.
- evt_run  out  RUN_W  length of the run that just ended.
- evt_ovf  out  1  sticky flag: an event was lost.

## Operation
- Decoder states:
  - UNSYNC: the reset state.
  - BLUE and RED: locked.
  - ERROR.
- Transitions apply only on cycles with `code_valid` = 1. With `code_valid` = 0, the state and the run counter hold.
- From UNSYNC:
  - code 1 -> BLUE; code 2 -> RED.
  - Run counter is set to 1; change_cnt is set to 0.
  - No event is produced on the first lock.
  - An illegal code -> ERROR.
- From BLUE or RED:
  - Same code: run counter increments, saturating at 2^RUN_W-1.
  - Opposite code: move to the other colour state; change_cnt increments (saturating); run counter is set to 1.
  - The same opposite-code cycle pushes an event: evt_color = new colour, evt_run = run counter value before the reset.
  - Illegal code -> ERROR.
- ERROR:
  - Holds until `clear` = 1, then -> UNSYNC.
  - Sampled codes are ignored while in ERROR.
- `clear` in any state -> UNSYNC. `clear` takes priority over `code_valid` in the same cycle; that code is discarded.
- `clear` does not reset the event buffer or evt_ovf. Only rst_n clears them.
- Event buffer (single entry):
  - Pop when evt_valid & evt_ready.
  - On a push when the buffer is full and no pop happens in the same cycle: the new event overwrites the old one and evt_ovf is set.
  - On a push and a pop in the same cycle: the new event loads and evt_ovf is not set.

## Timing
- Reset values (rst_n low at an edge): state UNSYNC, locked 0, color 0, err 0, change_cnt 0, run counter 0, evt_valid 0, evt_color 0, evt_run 0, evt_ovf 0.
- All outputs are registered. A code sampled at edge N is reflected in locked/color/err/change_cnt after edge N.
- evt_valid rises after the same edge N, i.e. 1-cycle latency from code to event.
- evt_color and evt_run are stable while evt_valid = 1 and evt_ready = 0. They change only on a push.
- evt_valid falls after the pop edge unless a push happens on that same edge.
- A code change followed by a return on consecutive valid cycles gives evt_run = 1 for the middle run.
- Run-counter saturation does not block events. evt_run then reports 2^RUN_W-1.

## Structure
- Shared package color_pkg:
  - Color_state enum (Blue = 1'h0, Red = 1'h1).
  - Wire-code constants COLOR_CODE_BLUE = 2'h1 and COLOR_CODE_RED = 2'h2.
  - Decoder state enum (UNSYNC, BLUE, RED, ERROR).
  - The encoder imports the same package.
- The event buffer is a natural sub-module, color_evt_buf: one-entry valid/ready register with overflow flag, parameterised by RUN_W.
- The decoder FSM, counters and next-state logic stay in color_code_decoder.

## Test plan
- Reset, then code 1 on 3 valid cycles -> locked=1, color=0, change_cnt=0, evt_valid=0.
- Codes 1,1,1,2 with evt_ready=1 -> one cycle after the 2, evt_valid=1, evt_color=1, evt_run=3, change_cnt=1.
- While locked Red, code 2'h3 -> err=1, locked=0. Then clear with code_valid=1, code=1 in the same cycle -> state UNSYNC, not BLUE. Next code 1 -> BLUE.
- evt_ready=0, codes 1,2,1 -> after the second change evt_color=0, evt_run=1, evt_ovf=1. Raising evt_ready clears evt_valid next cycle; evt_ovf stays 1.
- Push and pop in the same cycle (evt_valid=1, evt_ready=1, colour change) -> evt_valid stays 1 with the new event, evt_ovf stays 0.
- RUN_W=4, 20 cycles of code 2 then code 1 -> evt_run=15. Also drive rst_n low mid-run -> all outputs return to their reset values next cycle.
